qnigma_alu_mp: RTL and testbench



---
 rtl/qnigma_alu_mp.sv | 245 ++++++++++++++++++++++++
 tb/tb_qnigma_alu_mp.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qnigma_alu_mp.sv
// qnigma_alu_mp: multi-precision unsigned ALU (ADD, SUB, MUL, CMP) on N limbs of K bits.
// ADD/SUB/CMP process P limbs per cycle through a registered carry chain. MUL is
// operand-scanning and consumes one limb of B per cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          start request, taken only while rdy=1
//   op           00 ADD, 01 SUB, 10 MUL, 11 CMP (sampled on accept)
//   opa, opb     N*K-bit unsigned operands (sampled on accept)
//   rdy          idle, able to accept req
//   don          one-cycle completion pulse
//   res          2*N*K-bit result register
//   car          ADD carry-out, SUB/CMP borrow, 0 for MUL
//   eql, lt      A == B and A < B (unsigned), updated for every op
module qnigma_alu_mp #(
   parameter int unsigned N = 8,
   parameter int unsigned K = 32,
   parameter int unsigned P = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [1:0]       op,
   input  logic [N*K-1:0]   opa,
   input  logic [N*K-1:0]   opb,
   output logic             rdy,
   output logic             don,
   output logic [2*N*K-1:0] res,
   output logic             car,
   output logic             eql,
   output logic             lt
);

   localparam int unsigned NK    = N * K;
   localparam int unsigned NK2   = 2 * NK;
   localparam int unsigned PK    = P * K;
   localparam int unsigned MW    = (N + 1) * K;
   localparam int unsigned KK    = 2 * K;
   localparam int unsigned LW    = NK - K;
   localparam int unsigned SW    = $clog2(N);
   localparam int unsigned T_SER = N / P;

   // Reject geometries the limb-serial datapath cannot cover evenly
   generate
      if (N < 2 || P < 1 || P > N || (N % P) != 0) begin : g_bad_geometry
         $error("qnigma_alu_mp: illegal geometry, need N >= 2, 1 <= P <= N, N %% P == 0");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_CMP = 2'b11
   } op_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [SW-1:0]     s_q, s_d;
   logic [NK-1:0]     fa_q, fa_d;      // A, shifted down P limbs per step
   logic [NK-1:0]     fb_q, fb_d;      // B, shifted down P limbs per step
   logic [NK-1:0]     a_q, a_d;        // A, held whole for the multipliers
   logic [NK-1:0]     mb_q, mb_d;      // B, shifted down one limb per MUL step
   logic [NK2-1:0]    acc_q, acc_d;
   logic [NK-1:0]     sum_q, sum_d;
   logic              add_c_q, add_c_d;
   logic              sub_c_q, sub_c_d;
   logic              eq_q, eq_d;
   logic [NK2-1:0]    res_q, res_d;
   logic              car_q, car_d;
   logic              eql_q, eql_d;
   logic              lt_q, lt_d;
   logic              rdy_q, rdy_d;
   logic              don_q, don_d;

   logic [PK:0]       add_t;
   logic [PK:0]       sub_t;
   logic [PK-1:0]     slice;
   logic [KK-1:0]     pp;
   logic [MW-1:0]     partial;
   logic [MW-1:0]     acc_t;
   logic              last;

   assign rdy = rdy_q;
   assign don = don_q;
   assign res = res_q;
   assign car = car_q;
   assign eql = eql_q;
   assign lt  = lt_q;

   // Per-step arithmetic: P-limb add and subtract chains, A*b_j from N limb multipliers
   always_comb begin
      add_t   = {1'b0, fa_q[PK-1:0]} + {1'b0, fb_q[PK-1:0]} + {{PK{1'b0}}, add_c_q};
      sub_t   = {1'b0, fa_q[PK-1:0]} + {1'b0, ~fb_q[PK-1:0]} + {{PK{1'b0}}, sub_c_q};
      slice   = (op_q == OP_ADD) ? add_t[PK-1:0] : sub_t[PK-1:0];
      pp      = '0;
      partial = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pp      = KK'(a_q[i*K +: K]) * KK'(mb_q[K-1:0]);
         partial = partial + (MW'(pp) << (i * K));
      end
      // Upper N limbs of acc plus A*b_j always fits in N+1 limbs
      acc_t   = MW'(acc_q[NK2-1:NK]) + partial;
      last    = (op_q == OP_MUL) ? (s_q == SW'(N - 1)) : (s_q == SW'(T_SER - 1));
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      s_d     = s_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      a_d     = a_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      add_c_d = add_c_q;
      sub_c_d = sub_c_q;
      eq_d    = eq_q;
      res_d   = res_q;
      car_d   = car_q;
      eql_d   = eql_q;
      lt_d    = lt_q;
      rdy_d   = rdy_q;
      don_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            rdy_d = 1'b1;
            if (req && rdy_q) begin
               state_d = S_RUN;
               rdy_d   = 1'b0;
               op_d    = op_e'(op);
               s_d     = '0;
               fa_d    = opa;
               fb_d    = opb;
               a_d     = opa;
               mb_d    = opb;
               acc_d   = '0;
               sum_d   = '0;
               add_c_d = 1'b0;
               sub_c_d = 1'b1;
               eq_d    = 1'b1;
            end
         end

         S_RUN: begin
            // Flag scan keeps running past N/P steps during MUL; the zeroed
            // shift registers then leave carry and equality unchanged.
            fa_d    = fa_q >> PK;
            fb_d    = fb_q >> PK;
            add_c_d = add_t[PK];
            sub_c_d = sub_t[PK];
            eq_d    = eq_q & (fa_q[PK-1:0] == fb_q[PK-1:0]);
            sum_d   = (sum_q >> PK) | (NK'(slice) << (NK - PK));
            // acc shifts down one limb per step so A*b_j always lands in the top window
            acc_d   = {acc_t, {LW{1'b0}}} | NK2'(acc_q[NK-1:0] >> K);
            mb_d    = mb_q >> K;
            s_d     = s_q + SW'(1);
            if (last) begin
               state_d = S_DONE;
               don_d   = 1'b1;
               eql_d   = eq_d;
               lt_d    = ~sub_t[PK];
               case (op_q)
                  OP_ADD: begin
                     res_d = NK2'(sum_d);
                     car_d = add_t[PK];
                  end
                  OP_SUB: begin
                     res_d = NK2'(sum_d);
                     car_d = ~sub_t[PK];
                  end
                  OP_MUL: begin
                     res_d = acc_d;
                     car_d = 1'b0;
                  end
                  default: begin
                     car_d = ~sub_t[PK];
                  end
               endcase
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         s_q     <= '0;
         fa_q    <= '0;
         fb_q    <= '0;
         a_q     <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         add_c_q <= 1'b0;
         sub_c_q <= 1'b0;
         eq_q    <= 1'b0;
         res_q   <= '0;
         car_q   <= 1'b0;
         eql_q   <= 1'b0;
         lt_q    <= 1'b0;
         rdy_q   <= 1'b0;
         don_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         s_q     <= s_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         a_q     <= a_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         add_c_q <= add_c_d;
         sub_c_q <= sub_c_d;
         eq_q    <= eq_d;
         res_q   <= res_d;
         car_q   <= car_d;
         eql_q   <= eql_d;
         lt_q    <= lt_d;
         rdy_q   <= rdy_d;
         don_q   <= don_d;
      end
   end

endmodule

// File: tb/tb_qnigma_alu_mp.sv
// tb_qnigma_alu_mp: bench for qnigma_alu_mp at N=4, K=8, P=2.
// A behavioural model (plain 32/64-bit arithmetic plus a latency counter) is
// compared against every output on every cycle; directed cases pin the model
// with hand-computed values, then randomized operations follow.
module tb_qnigma_alu_mp;

   localparam int unsigned N  = 4;
   localparam int unsigned K  = 8;
   localparam int unsigned P  = 2;
   localparam int unsigned NK = N * K;

   logic            clk = 1'b0;
   logic            rst;
   logic            req;
   logic [1:0]      op;
   logic [NK-1:0]   opa;
   logic [NK-1:0]   opb;
   logic            rdy;
   logic            don;
   logic [2*NK-1:0] res;
   logic            car;
   logic            eql;
   logic            lt;

   qnigma_alu_mp #(.N(N), .K(K), .P(P)) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .op  (op),
      .opa (opa),
      .opb (opb),
      .rdy (rdy),
      .don (don),
      .res (res),
      .car (car),
      .eql (eql),
      .lt  (lt)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model state
   logic            started = 1'b0;
   logic            m_rdy   = 1'b0;
   logic            m_don   = 1'b0;
   logic            m_busy  = 1'b0;
   logic            m_car   = 1'b0;
   logic            m_eql   = 1'b0;
   logic            m_lt    = 1'b0;
   logic [2*NK-1:0] m_res   = '0;
   int              m_cnt   = 0;
   logic [1:0]      p_op    = 2'b00;
   logic [NK-1:0]   p_a     = '0;
   logic [NK-1:0]   p_b     = '0;

   // {car, res} an operation must produce, straight from integer arithmetic
   function automatic logic [2*NK:0] golden(input logic [1:0] o, input logic [NK-1:0] a,
                                            input logic [NK-1:0] b, input logic [2*NK-1:0] prev);
      logic [NK:0]     s;
      logic [2*NK-1:0] prod;
      logic [NK-1:0]   d;
      logic            borrow;
      borrow = (a < b);
      case (o)
         2'b00: begin
            s      = {1'b0, a} + {1'b0, b};
            golden = {s[NK], {NK{1'b0}}, s[NK-1:0]};
         end
         2'b01: begin
            d      = a - b;
            golden = {borrow, {NK{1'b0}}, d};
         end
         2'b10: begin
            prod   = {{NK{1'b0}}, a} * {{NK{1'b0}}, b};
            golden = {1'b0, prod};
         end
         default: golden = {borrow, prev};
      endcase
   endfunction

   // Model: result appears N/P (N for MUL) edges after accept, rdy returns one edge later
   always @(posedge clk) begin
      if (rst) begin
         started <= 1'b1;
         m_rdy   <= 1'b0;
         m_don   <= 1'b0;
         m_busy  <= 1'b0;
         m_res   <= '0;
         m_car   <= 1'b0;
         m_eql   <= 1'b0;
         m_lt    <= 1'b0;
      end else if (m_don) begin
         m_don <= 1'b0;
         m_rdy <= 1'b1;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy           <= 1'b0;
            m_don            <= 1'b1;
            m_eql            <= (p_a == p_b);
            m_lt             <= (p_a < p_b);
            {m_car, m_res}   <= golden(p_op, p_a, p_b, m_res);
         end
      end else if (m_rdy && req) begin
         p_op   <= op;
         p_a    <= opa;
         p_b    <= opb;
         m_cnt  <= (op == 2'b10) ? int'(N) : int'(N / P);
         m_busy <= 1'b1;
         m_rdy  <= 1'b0;
      end else begin
         m_rdy <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [2*NK-1:0] act, input logic [2*NK-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (rdy !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (rdy !== 1'b1) fail_timeout("wait_rdy");
   endtask

   // Issue one request; returns at the negedge of cycle 1 after accept
   task automatic start_op(input logic [1:0] o, input logic [NK-1:0] a, input logic [NK-1:0] b);
      wait_rdy();
      op  = o;
      opa = a;
      opb = b;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Returns the cycle number (accept cycle = 0) in which don is seen
   task automatic wait_done(input bit noisy, output int cyc);
      cyc = 1;
      while (don !== 1'b1 && cyc < 40) begin
         if (noisy) begin
            req = 1'($urandom_range(0, 1));
            opa = $urandom;
         end
         @(negedge clk);
         cyc++;
      end
      req = 1'b0;
      if (don !== 1'b1) fail_timeout("wait_done");
   endtask

   initial begin
      int cyc;
      int dons;
      int first;
      int second;
      logic [1:0]      ro;
      logic [NK-1:0]   ra;
      logic [NK-1:0]   rb;
      logic [2*NK-1:0] mul_res;

      rst = 1'b1;
      req = 1'b0;
      op  = 2'b00;
      opa = '0;
      opb = '0;

      // Every-cycle comparison against the model
      fork
         forever begin
            @(negedge clk);
            if (started) begin
               chk("rdy", {{(2*NK-1){1'b0}}, rdy}, {{(2*NK-1){1'b0}}, m_rdy});
               chk("don", {{(2*NK-1){1'b0}}, don}, {{(2*NK-1){1'b0}}, m_don});
               chk("res", res, m_res);
               chk("car", {{(2*NK-1){1'b0}}, car}, {{(2*NK-1){1'b0}}, m_car});
               chk("eql", {{(2*NK-1){1'b0}}, eql}, {{(2*NK-1){1'b0}}, m_eql});
               chk("lt",  {{(2*NK-1){1'b0}}, lt},  {{(2*NK-1){1'b0}}, m_lt});
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_rdy", 64'(rdy), 64'd0);
      chk("reset_don", 64'(don), 64'd0);
      chk("reset_res", res, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_reset", 64'(rdy), 64'd1);

      // ADD wrap-around
      start_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
      wait_done(1'b0, cyc);
      chk("add_cycle", 64'(cyc), 64'd3);
      chk("add_res", res, 64'h0);
      chk("add_car", 64'(car), 64'd1);
      chk("add_eql", 64'(eql), 64'd0);
      chk("add_lt",  64'(lt),  64'd0);

      // SUB both directions
      start_op(2'b01, 32'h5, 32'h7);
      wait_done(1'b0, cyc);
      chk("sub57_res", res, 64'h0000_0000_FFFF_FFFE);
      chk("sub57_car", 64'(car), 64'd1);
      chk("sub57_lt",  64'(lt),  64'd1);
      chk("sub57_eql", 64'(eql), 64'd0);
      start_op(2'b01, 32'h7, 32'h5);
      wait_done(1'b0, cyc);
      chk("sub75_res", res, 64'h2);
      chk("sub75_car", 64'(car), 64'd0);
      chk("sub75_lt",  64'(lt),  64'd0);

      // MUL largest operands
      start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1'b0, cyc);
      chk("mulmax_cycle", 64'(cyc), 64'd5);
      chk("mulmax_res", res, 64'hFFFF_FFFE_0000_0001);
      chk("mulmax_car", 64'(car), 64'd0);
      chk("mulmax_eql", 64'(eql), 64'd1);
      chk("mulmax_lt",  64'(lt),  64'd0);

      // MUL, then CMP must leave res alone
      start_op(2'b10, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_done(1'b0, cyc);
      mul_res = 64'h0B00_EA4E_242D_2080;
      chk("mul_res", res, mul_res);
      start_op(2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait_done(1'b0, cyc);
      chk("cmp_eql", 64'(eql), 64'd1);
      chk("cmp_lt",  64'(lt),  64'd0);
      chk("cmp_car", 64'(car), 64'd0);
      chk("cmp_res_kept", res, mul_res);

      // req held through a busy ADD: only the accept at cycle 4 may follow
      wait_rdy();
      op     = 2'b00;
      opa    = 32'h0000_1111;
      opb    = 32'h0000_2222;
      req    = 1'b1;
      dons   = 0;
      first  = 0;
      second = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 5) req = 1'b0;
         if (don === 1'b1) begin
            dons++;
            if (first == 0) first = c;
            else second = c;
         end
      end
      chk("busy_don_count", 64'(dons), 64'd2);
      chk("busy_first_don", 64'(first), 64'd3);
      chk("busy_second_don", 64'(second), 64'd7);

      // Reset during MUL, with req also asserted
      start_op(2'b10, 32'h0102_0304, 32'h0506_0708);
      @(negedge clk);
      rst = 1'b1;
      req = 1'b1;
      dons = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (don === 1'b1) dons++;
         chk("abort_rdy", 64'(rdy), 64'd0);
         chk("abort_res", res, 64'd0);
      end
      rst = 1'b0;
      req = 1'b0;
      @(negedge clk);
      if (don === 1'b1) dons++;
      chk("abort_no_don", 64'(dons), 64'd0);
      chk("abort_rdy_back", 64'(rdy), 64'd1);
      start_op(2'b00, 32'h1, 32'h1);
      wait_done(1'b0, cyc);
      chk("post_abort_add", res, 64'h2);

      // Randomized operations, some with equal operands and noise on req while busy
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra + NK'($urandom_range(0, 2)) - NK'(1);
            default: rb = $urandom;
         endcase
         start_op(ro, ra, rb);
         wait_done(1'($urandom_range(0, 1)), cyc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
